letc_core_rf_write_arbiter: RTL and testbench
=============================================

// Module: letc_core_rf_write_arbiter
// PURPOSE
//  Shares the single integer register-file write port between the writeback stage and NUM_AUX
//  long-latency producers (mul/div, refill); sits between writeback and the RF.
//  Pipeline has priority; aux requesters are served round-robin in idle slots.
//  If an aux requester is starved for STARVE_LIMIT cycles, the block stalls writeback for one forced slot.
// PARAMETERS
//  NUM_AUX       2   number of auxiliary write requesters (>=1)
//  STARVE_LIMIT  8   consecutive starved cycles before a forced slot (>=1, <=255)
// PORTS
//  clk           in   1               core clock
//  rst_n         in   1               asynchronous active-low reset
//  wb_rd_idx     in   5               writeback destination index (reg_idx_t)
//  wb_rd_val     in   32              writeback data (word_t)
//  wb_rd_we      in   1               writeback write enable (already valid-qualified)
//  wb_stall_req  out  1               registered stall request to writeback (forced slot)
//  aux_valid     in   NUM_AUX         aux write request
//  aux_ready     out  NUM_AUX         aux grant; transfer when valid&&ready
//  aux_rd_idx    in   NUM_AUX x 5     aux destination index
//  aux_rd_val    in   NUM_AUX x 32    aux data
//  rf_rd_idx     out  5               RF write index
//  rf_rd_val     out  32              RF write data
//  rf_rd_we      out  1               RF write enable
//  perf_stall_cnt out 32              forced-slot cycle count (see CONFIGURATION)
//  perf_aux_cnt  out  32              completed aux writes (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=NORMAL, rr_ptr=0, starve_cnt=0, wb_stall_req=0, perf counters=0.
//    aux_ready, rf_rd_we=0 while in reset.
//  - Write mux is combinational, zero latency; only arbitration state is registered.
//  - NORMAL: wb_rd_we=1 -> RF gets wb fields, all aux_ready=0.
//    Else the RR winner among aux_valid from rr_ptr gets aux_ready=1 and RF gets its fields.
//  - rr_ptr <= winner+1 (mod NUM_AUX) on each aux transfer; unchanged otherwise.
//  - starve_cnt: +1 each NORMAL cycle with |aux_valid && no aux transfer; cleared on any aux transfer or when no aux_valid.
//  - NORMAL->FORCE when starve_cnt==STARVE_LIMIT-1 and still starved; wb_stall_req<=1 same edge.
//  - FORCE (exactly one cycle): wb_rd_we is masked (writeback guarantees 0 while stalled; SVA checks).
//    RR winner is granted; next state NORMAL, wb_stall_req<=0, starve_cnt<=0.
//  - FORCE with no aux_valid: no write; still returns to NORMAL (no deadlock).
//  - Aux rule: aux_valid and payload hold until ready; aux_ready never depends on its own past ready.
//  - Same rd_idx on wb and aux in one cycle: wb wins, aux waits.
//    RAW ordering is the scoreboard's job, not this block's.
//  - Writes to x0 pass through unchanged; the RF discards them.
//  - Reset asserted mid-FORCE: immediately NORMAL and stall deasserted (async).
// CONFIGURATION
//  LETC_CORE_RF_WARB_PERF_EN defined:
//    perf_stall_cnt +1 per FORCE cycle; perf_aux_cnt +1 per aux transfer; both wrap at 2^32.
//  Not defined: counters not built, both ports tied to 0.
// STRUCTURE
//  letc_core_pkg: rf_warb_state_e {RF_WARB_NORMAL, RF_WARB_FORCE}; RF_WARB_CNT_W localparam.
//  reg_idx_t, word_t come from existing packages.
//  Sub-module letc_core_rr_arbiter: NUM_AUX req vector + ptr -> one-hot grant, winner idx.
//    Purely combinational, reusable elsewhere.
// TESTING
//  1. Reset released, aux_valid=0, wb writes x5=0x1234 -> rf_rd_we=1, idx 5, val 0x1234, same cycle.
//  2. wb idle, aux0 and aux1 valid continuously -> grants alternate 0,1,0,1; rr_ptr wraps.
//  3. wb_rd_we=1 every cycle, aux1 valid from cycle 0, STARVE_LIMIT=8
//     -> wb_stall_req=1 in cycle 8 only; aux1 written in cycle 8; stall low in cycle 9.
//  4. wb and aux0 target x7 in the same cycle -> wb value written; aux0 written next idle cycle.
//  5. rst_n asserted during FORCE -> wb_stall_req and aux_ready low immediately; NORMAL after release.
//  6. PERF_EN, 3 forced slots + 10 aux writes -> perf_stall_cnt=3, perf_aux_cnt=10.
//     Without the macro both read 0.

Source files
------------

// File: rtl/letc_core_pkg.sv
// -----------------------------------------------------------------------------
// letc_core_pkg
//   Shared types for the core's register-file write path.
//   reg_idx_t  : integer register index (x0..x31)
//   word_t     : integer data word
//   rf_warb_state_e : register-file write arbiter FSM state
//   RF_WARB_CNT_W   : width of the arbiter's starvation counter (limit <= 255)
// -----------------------------------------------------------------------------
package letc_core_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    RF_WARB_NORMAL = 1'b0,
    RF_WARB_FORCE  = 1'b1
  } rf_warb_state_e;

  localparam int RF_WARB_CNT_W = 8;
  localparam int PERF_CNT_W    = 32;

endpackage

// File: rtl/letc_core_rr_arbiter.sv
// -----------------------------------------------------------------------------
// letc_core_rr_arbiter
//   Purely combinational round-robin pick. Scans req starting at index ptr and
//   wrapping; the first set bit wins.
//   Ports:
//     req    in  NUM_REQ   request vector
//     ptr    in  PTR_W     highest-priority index for this cycle (< NUM_REQ)
//     grant  out NUM_REQ   one-hot grant (all zero when no request)
//     winner out PTR_W     index of the granted request (0 when none)
//     valid  out 1         at least one request present
// -----------------------------------------------------------------------------
module letc_core_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    int j;
    j      = 0;
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        winner   = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/letc_core_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// letc_core_rf_write_arbiter
//   Shares the single integer register-file write port between the writeback
//   stage and NUM_AUX long-latency producers. Writeback has priority; aux
//   requesters are served round-robin in idle slots. An aux requester starved
//   for STARVE_LIMIT consecutive cycles earns one forced slot, during which
//   writeback is stalled via wb_stall_req.
//
//   Handshake (aux side): a transfer happens on a cycle where
//   aux_valid[i] && aux_ready[i]. The requester holds valid and payload until
//   that cycle. aux_ready is a pure function of this cycle's inputs and the
//   registered arbitration state, never of a past ready.
//
//   Ports:
//     clk, rst_n                    clock, async active-low reset
//     wb_rd_idx/wb_rd_val/wb_rd_we  writeback write request
//     wb_stall_req                  registered stall to writeback (forced slot)
//     aux_valid/aux_ready           per-requester handshake
//     aux_rd_idx/aux_rd_val         per-requester payload
//     rf_rd_idx/rf_rd_val/rf_rd_we  register-file write port (combinational mux)
//     perf_stall_cnt/perf_aux_cnt   performance counters
//     dbg_state                     current FSM state, for observation
//
//   Build option: LETC_CORE_RF_WARB_PERF_EN builds the performance counters
//   (forced-slot cycles, completed aux writes; both wrap). Without it both
//   counter ports read 0.
// -----------------------------------------------------------------------------
module letc_core_rf_write_arbiter
  import letc_core_pkg::*;
#(
  parameter int NUM_AUX      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  reg_idx_t                   wb_rd_idx,
  input  word_t                      wb_rd_val,
  input  logic                       wb_rd_we,
  output logic                       wb_stall_req,
  input  logic [NUM_AUX-1:0]         aux_valid,
  output logic [NUM_AUX-1:0]         aux_ready,
  input  reg_idx_t [NUM_AUX-1:0]     aux_rd_idx,
  input  word_t    [NUM_AUX-1:0]     aux_rd_val,
  output reg_idx_t                   rf_rd_idx,
  output word_t                      rf_rd_val,
  output logic                       rf_rd_we,
  output logic [PERF_CNT_W-1:0]      perf_stall_cnt,
  output logic [PERF_CNT_W-1:0]      perf_aux_cnt,
  output rf_warb_state_e             dbg_state
);

  localparam int PTR_W = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;

  rf_warb_state_e           state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [RF_WARB_CNT_W-1:0] starve_cnt;

  logic [NUM_AUX-1:0] rr_grant;
  logic [PTR_W-1:0]   rr_winner;
  logic               rr_valid;
  logic               wb_sel;
  logic               aux_xfer;
  logic               starved;
  logic [PTR_W-1:0]   ptr_next;

  letc_core_rr_arbiter #(
    .NUM_REQ (NUM_AUX),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req    (aux_valid),
    .ptr    (rr_ptr),
    .grant  (rr_grant),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  // Writeback is masked in the forced slot; it is supposed to be idle anyway.
  assign wb_sel   = (state == RF_WARB_NORMAL) && wb_rd_we;
  assign aux_xfer = rst_n && !wb_sel && rr_valid;
  assign starved  = (|aux_valid) && !aux_xfer;
  assign ptr_next = (int'(rr_winner) == NUM_AUX - 1) ? '0 : rr_winner + PTR_W'(1);
  assign dbg_state = state;

  // Zero-latency write mux; outputs are forced quiet while reset is held.
  always_comb begin
    rf_rd_idx = wb_rd_idx;
    rf_rd_val = wb_rd_val;
    rf_rd_we  = 1'b0;
    aux_ready = '0;
    if (rst_n) begin
      if (wb_sel) begin
        rf_rd_we = 1'b1;
      end else if (rr_valid) begin
        aux_ready = rr_grant;
        rf_rd_idx = aux_rd_idx[rr_winner];
        rf_rd_val = aux_rd_val[rr_winner];
        rf_rd_we  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RF_WARB_NORMAL;
      rr_ptr       <= '0;
      starve_cnt   <= '0;
      wb_stall_req <= 1'b0;
    end else begin
      if (aux_xfer) begin
        rr_ptr <= ptr_next;
      end
      case (state)
        RF_WARB_NORMAL: begin
          if (starved) begin
            starve_cnt <= starve_cnt + RF_WARB_CNT_W'(1);
            // Counter reaching LIMIT-1 while still starved means this is the
            // LIMIT-th starved cycle: claim the next slot.
            if (starve_cnt == RF_WARB_CNT_W'(STARVE_LIMIT - 1)) begin
              state        <= RF_WARB_FORCE;
              wb_stall_req <= 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        RF_WARB_FORCE: begin
          // One cycle only, whether or not anyone was still requesting.
          state        <= RF_WARB_NORMAL;
          wb_stall_req <= 1'b0;
          starve_cnt   <= '0;
        end
        default: begin
          state        <= RF_WARB_NORMAL;
          wb_stall_req <= 1'b0;
          starve_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef LETC_CORE_RF_WARB_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q;
  logic [PERF_CNT_W-1:0] aux_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      aux_cnt_q   <= '0;
    end else begin
      if (state == RF_WARB_FORCE) begin
        stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
      end
      if (aux_xfer) begin
        aux_cnt_q <= aux_cnt_q + PERF_CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_aux_cnt   = aux_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_aux_cnt   = '0;
`endif

  // Writeback must not present a write while it is being stalled.
  a_wb_idle_in_force: assert property (
    @(posedge clk) disable iff (!rst_n) (state == RF_WARB_FORCE) |-> !wb_rd_we
  );

endmodule

// File: tb/tb_letc_core_rf_write_arbiter.sv
module tb_letc_core_rf_write_arbiter;
  import letc_core_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]       wb_rd_idx;
  logic [31:0]      wb_rd_val;
  logic             wb_rd_we;
  logic             wb_stall_req;
  logic [1:0]       aux_valid;
  logic [1:0]       aux_ready;
  logic [1:0][4:0]  aux_rd_idx;
  logic [1:0][31:0] aux_rd_val;
  logic [4:0]       rf_rd_idx;
  logic [31:0]      rf_rd_val;
  logic             rf_rd_we;
  logic [31:0]      perf_stall_cnt;
  logic [31:0]      perf_aux_cnt;
  rf_warb_state_e   dbg_state;

  letc_core_rf_write_arbiter #(
    .NUM_AUX      (2),
    .STARVE_LIMIT (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_rd_idx      (wb_rd_idx),
    .wb_rd_val      (wb_rd_val),
    .wb_rd_we       (wb_rd_we),
    .wb_stall_req   (wb_stall_req),
    .aux_valid      (aux_valid),
    .aux_ready      (aux_ready),
    .aux_rd_idx     (aux_rd_idx),
    .aux_rd_val     (aux_rd_val),
    .rf_rd_idx      (rf_rd_idx),
    .rf_rd_val      (rf_rd_val),
    .rf_rd_we       (rf_rd_we),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_aux_cnt   (perf_aux_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic we, input logic [4:0] idx, input logic [31:0] val,
                       input logic [1:0] av, input logic [4:0] i0, input logic [31:0] v0,
                       input logic [4:0] i1, input logic [31:0] v1);
    wb_rd_we      = we;
    wb_rd_idx     = idx;
    wb_rd_val     = val;
    aux_valid     = av;
    aux_rd_idx[0] = i0;
    aux_rd_val[0] = v0;
    aux_rd_idx[1] = i1;
    aux_rd_val[1] = v1;
  endtask

  // Writeback writes x3 every cycle except the cycle it is told to stall;
  // aux1 waits from cycle 0 and must get the forced slot in cycle 8.
  task automatic run_starve(input logic [4:0] idx, input logic [31:0] val);
    logic pending;
    pending = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      drive((c != 8), 5'd3, 32'h3000 + c, pending ? 2'b10 : 2'b00, 5'd0, 32'h0, idx, val);
      #1;
      check($sformatf("starve_stall_c%0d", c), 32'(wb_stall_req), (c == 8) ? 32'd1 : 32'd0);
      check($sformatf("starve_ready_c%0d", c), 32'(aux_ready), (c == 8) ? 32'd2 : 32'd0);
      check($sformatf("starve_we_c%0d", c), 32'(rf_rd_we), 32'd1);
      check($sformatf("starve_idx_c%0d", c), 32'(rf_rd_idx), (c == 8) ? 32'(idx) : 32'd3);
      if (c == 8) begin
        check("starve_val_force", rf_rd_val, val);
        check("starve_state_force", 32'(dbg_state), 32'(RF_WARB_FORCE));
        pending = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_idx;
    logic [31:0] wb_val;
    logic [1:0]  av;
    logic [4:0]  a0_idx;
    logic [31:0] a0_val;
    logic [4:0]  a1_idx;
    logic [31:0] a1_val;
    logic        e_we;
    logic [4:0]  e_idx;
    logic [31:0] e_val;
    logic [1:0]  e_ready;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] exp_stall;
    logic [31:0] exp_aux;

    // wb write, no aux
    vecs[0]  = '{1'b1, 5'd5, 32'h1234,     2'b00, 5'd0, 32'h0,   5'd0, 32'h0,  1'b1, 5'd5, 32'h1234,     2'b00};
    // wb idle, both aux valid: grants alternate 0,1,0,1
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd1, 32'hA0,  5'd2, 32'hB1, 1'b1, 5'd1, 32'hA0,       2'b01};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd1, 32'hA0,  5'd2, 32'hB1, 1'b1, 5'd2, 32'hB1,       2'b10};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd1, 32'hA0,  5'd2, 32'hB1, 1'b1, 5'd1, 32'hA0,       2'b01};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd1, 32'hA0,  5'd2, 32'hB1, 1'b1, 5'd2, 32'hB1,       2'b10};
    // wb and aux0 both to x7: wb wins, aux0 next idle cycle
    vecs[5]  = '{1'b1, 5'd7, 32'h7777,     2'b01, 5'd7, 32'hAAA, 5'd0, 32'h0,  1'b1, 5'd7, 32'h7777,     2'b00};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd7, 32'hAAA, 5'd0, 32'h0,  1'b1, 5'd7, 32'hAAA,      2'b00 | 2'b01};
    // x0 write passes through
    vecs[7]  = '{1'b1, 5'd0, 32'hDEAD,     2'b00, 5'd0, 32'h0,   5'd0, 32'h0,  1'b1, 5'd0, 32'hDEAD,     2'b00};
    // nothing to do
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        2'b00, 5'd0, 32'h0,   5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        2'b00};
    // ptr=1 but only aux0 valid: scan wraps to 0
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd4, 32'h44,  5'd0, 32'h0,  1'b1, 5'd4, 32'h44,       2'b01};
    // ptr=1, only aux1 valid
    vecs[10] = '{1'b0, 5'd0, 32'h0,        2'b10, 5'd0, 32'h0,   5'd6, 32'h66, 1'b1, 5'd6, 32'h66,       2'b10};

    // Reset with requests present: nothing may leak out.
    rst_n = 1'b0;
    drive(1'b1, 5'd9, 32'h9, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rf_we", 32'(rf_rd_we), 32'd0);
    check("rst_aux_ready", 32'(aux_ready), 32'd0);
    check("rst_stall", 32'(wb_stall_req), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(RF_WARB_NORMAL));
    check("rst_perf_stall", perf_stall_cnt, 32'd0);
    check("rst_perf_aux", perf_aux_cnt, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rst_n = 1'b1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].wb_we, vecs[i].wb_idx, vecs[i].wb_val, vecs[i].av,
            vecs[i].a0_idx, vecs[i].a0_val, vecs[i].a1_idx, vecs[i].a1_val);
      #1;
      check($sformatf("vec%0d_we", i), 32'(rf_rd_we), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_ready", i), 32'(aux_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_stall", i), 32'(wb_stall_req), 32'd0);
      if (vecs[i].e_we) begin
        check($sformatf("vec%0d_idx", i), 32'(rf_rd_idx), 32'(vecs[i].e_idx));
        check($sformatf("vec%0d_val", i), rf_rd_val, vecs[i].e_val);
      end
    end

    // Starvation: one forced slot in cycle 8.
    run_starve(5'd9, 32'h99);

    // Reset during the forced slot.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd3, 32'h5000 + c, 2'b01, 5'd8, 32'h88, 5'd0, 32'h0);
    end
    @(negedge clk);
    drive(1'b0, 5'd3, 32'h0, 2'b01, 5'd8, 32'h88, 5'd0, 32'h0);
    #1;
    check("rstforce_pre_stall", 32'(wb_stall_req), 32'd1);
    check("rstforce_pre_ready", 32'(aux_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstforce_stall", 32'(wb_stall_req), 32'd0);
    check("rstforce_ready", 32'(aux_ready), 32'd0);
    check("rstforce_we", 32'(rf_rd_we), 32'd0);
    check("rstforce_state", 32'(dbg_state), 32'(RF_WARB_NORMAL));
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rstrel_state", 32'(dbg_state), 32'(RF_WARB_NORMAL));
    check("rstrel_perf_stall", perf_stall_cnt, 32'd0);
    check("rstrel_perf_aux", perf_aux_cnt, 32'd0);
    @(negedge clk);
    #1;
    check("rstrel_stall_after_edge", 32'(wb_stall_req), 32'd0);

    // Perf: 7 idle-slot aux writes, then 3 forced slots (each one more aux write).
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd10 + 5'(c), 32'h100 + c, 5'd0, 32'h0);
      #1;
      check($sformatf("perf_idle_ready_%0d", c), 32'(aux_ready), 32'd1);
      check($sformatf("perf_idle_idx_%0d", c), 32'(rf_rd_idx), 32'd10 + c);
    end
    run_starve(5'd20, 32'h2000);
    run_starve(5'd21, 32'h2100);
    run_starve(5'd22, 32'h2200);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
`ifdef LETC_CORE_RF_WARB_PERF_EN
    exp_stall = 32'd3;
    exp_aux   = 32'd10;
`else
    exp_stall = 32'd0;
    exp_aux   = 32'd0;
`endif
    check("perf_stall_cnt", perf_stall_cnt, exp_stall);
    check("perf_aux_cnt", perf_aux_cnt, exp_aux);

    // ------------------------------------------------------------ report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
